// File: rtl/knight_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : knight_motion_ctrl
// Purpose  : Per-frame Knight movement/action sequencer (idle/walk/jump/fall/
//            attack) driving signed X/Y step commands, status and facing.
// Revision : 1.0 - initial release
// ============================================================================
module knight_motion_ctrl #(
   parameter int         WALK_STEP     = 2,
   parameter int         JUMP_STEP     = 6,
   parameter int         FALL_STEP     = 6,
   parameter int         JUMP_FRAMES   = 18,
   parameter int         ATTACK_FRAMES = 8,
   parameter int         ATTACK_CD     = 12,
   parameter logic [7:0] KEY_LEFT      = 8'h50,
   parameter logic [7:0] KEY_RIGHT     = 8'h4F,
   parameter logic [7:0] KEY_JUMP      = 8'h52,
   parameter logic [7:0] KEY_ATTACK    = 8'h1B
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   input  logic       on_ground,
   input  logic       head_hit,
   output logic [9:0] x_step,
   output logic [9:0] y_step,
   output logic [3:0] status,
   output logic       facing_left,
   output logic       attack_active
);

   localparam int c_jw = $clog2(JUMP_FRAMES + 1);
   localparam int c_aw = $clog2(ATTACK_FRAMES + 1);
   localparam int c_cw = $clog2(ATTACK_CD + 1);

   localparam logic [c_jw-1:0] c_jcnt_last = c_jw'(JUMP_FRAMES - 1);
   localparam logic [c_aw-1:0] c_acnt_last = c_aw'(ATTACK_FRAMES - 1);
   localparam logic [c_cw-1:0] c_cd_load   = c_cw'(ATTACK_CD);

   localparam logic [9:0] c_walk_pos = 10'(WALK_STEP);
   localparam logic [9:0] c_walk_neg = 10'(-WALK_STEP);
   localparam logic [9:0] c_jump_neg = 10'(-JUMP_STEP);
   localparam logic [9:0] c_fall_pos = 10'(FALL_STEP);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WALK   = 3'd1,
      ST_JUMP   = 3'd2,
      ST_FALL   = 3'd3,
      ST_ATTACK = 3'd4
   } state_t;

   state_t          r_state;
   logic [7:0]      r_prev_key;
   logic [c_jw-1:0] r_jcnt;
   logic [c_aw-1:0] r_acnt;
   logic [c_cw-1:0] r_cd;
   logic [9:0]      r_x_step;
   logic [9:0]      r_y_step;
   logic            r_facing_left;
   logic            r_attack_active;

   logic [7:0] w_key;
   logic       w_left;
   logic       w_right;
   logic       w_jump_edge;
   logic       w_attack_edge;
   logic [9:0] w_air_x;
   logic [9:0] w_attack_y;

   // Unknown keycodes collapse to "no key" so they also count as a release.
   always_comb begin
      w_key = 8'h00;
      if (keycode == KEY_LEFT || keycode == KEY_RIGHT ||
          keycode == KEY_JUMP || keycode == KEY_ATTACK)
         w_key = keycode;
   end

   assign w_left        = (w_key == KEY_LEFT);
   assign w_right       = (w_key == KEY_RIGHT);
   assign w_jump_edge   = (w_key == KEY_JUMP)   && (r_prev_key != KEY_JUMP);
   assign w_attack_edge = (w_key == KEY_ATTACK) && (r_prev_key != KEY_ATTACK);
   assign w_air_x       = w_left ? c_walk_neg : (w_right ? c_walk_pos : 10'd0);
   assign w_attack_y    = on_ground ? 10'd0 : c_fall_pos;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_state         <= ST_IDLE;
         r_prev_key      <= 8'h00;
         r_jcnt          <= '0;
         r_acnt          <= '0;
         r_cd            <= '0;
         r_x_step        <= 10'd0;
         r_y_step        <= 10'd0;
         r_facing_left   <= 1'b0;
         r_attack_active <= 1'b0;
      end else begin
         r_prev_key <= w_key;
         if (r_state != ST_ATTACK && r_cd != '0)
            r_cd <= r_cd - 1'b1;

         case (r_state)
            ST_IDLE, ST_WALK: begin
               r_attack_active <= 1'b0;
               if (w_attack_edge && r_cd == '0) begin
                  r_state         <= ST_ATTACK;
                  r_acnt          <= '0;
                  r_attack_active <= 1'b1;
                  r_x_step        <= 10'd0;
                  r_y_step        <= w_attack_y;
               end else if (w_jump_edge && on_ground) begin
                  r_state  <= ST_JUMP;
                  r_jcnt   <= '0;
                  r_x_step <= w_air_x;
                  r_y_step <= c_jump_neg;
               end else if (!on_ground) begin
                  r_state  <= ST_FALL;
                  r_x_step <= w_air_x;
                  r_y_step <= c_fall_pos;
                  if (w_left)  r_facing_left <= 1'b1;
                  if (w_right) r_facing_left <= 1'b0;
               end else if (w_left || w_right) begin
                  r_state       <= ST_WALK;
                  r_x_step      <= w_air_x;
                  r_y_step      <= 10'd0;
                  r_facing_left <= w_left;
               end else begin
                  r_state  <= ST_IDLE;
                  r_x_step <= 10'd0;
                  r_y_step <= 10'd0;
               end
            end

            // Releasing the jump key cuts the rise short (variable jump height).
            ST_JUMP: begin
               r_x_step <= w_air_x;
               if (w_left)  r_facing_left <= 1'b1;
               if (w_right) r_facing_left <= 1'b0;
               if (head_hit || r_jcnt == c_jcnt_last || w_key != KEY_JUMP) begin
                  r_state  <= ST_FALL;
                  r_y_step <= c_fall_pos;
               end else begin
                  r_jcnt   <= r_jcnt + 1'b1;
                  r_y_step <= c_jump_neg;
               end
            end

            ST_FALL: begin
               r_x_step <= w_air_x;
               if (w_left)  r_facing_left <= 1'b1;
               if (w_right) r_facing_left <= 1'b0;
               if (on_ground) begin
                  r_state  <= (w_left || w_right) ? ST_WALK : ST_IDLE;
                  r_y_step <= 10'd0;
               end else begin
                  r_y_step <= c_fall_pos;
               end
            end

            ST_ATTACK: begin
               r_x_step <= 10'd0;
               r_y_step <= w_attack_y;
               if (r_acnt == c_acnt_last) begin
                  r_state         <= on_ground ? ST_IDLE : ST_FALL;
                  r_attack_active <= 1'b0;
                  r_cd            <= c_cd_load;
               end else begin
                  r_acnt          <= r_acnt + 1'b1;
                  r_attack_active <= 1'b1;
               end
            end

            default: begin
               r_state         <= ST_IDLE;
               r_x_step        <= 10'd0;
               r_y_step        <= 10'd0;
               r_attack_active <= 1'b0;
            end
         endcase
      end
   end

   assign x_step        = r_x_step;
   assign y_step        = r_y_step;
   assign status        = {1'b0, r_state};
   assign facing_left   = r_facing_left;
   assign attack_active = r_attack_active;

endmodule
`default_nettype wire
